// File: rtl/data_sync_ack_pkg.sv
// ---------------------------------------------------------------------------
// sync_pkg
// Purpose : Shared constants for the destination-side bus synchronizer and
//           for the single-bit synchronizer that other blocks reuse.
// Contents: default synchronizer depth, default bus width, and the legal
//           range of synchronizer depths, plus a range-check helper.
// ---------------------------------------------------------------------------
package sync_pkg;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_BUS_WIDTH   = 8;
  localparam int MIN_SYNC_STAGES = 2;
  localparam int MAX_SYNC_STAGES = 4;

  // True when a requested synchronizer depth is within the supported range.
  function automatic bit stages_legal(input int stages);
    return (stages >= MIN_SYNC_STAGES) && (stages <= MAX_SYNC_STAGES);
  endfunction

endpackage

// File: rtl/data_sync_ack_bit_sync.sv
// ---------------------------------------------------------------------------
// bit_sync
// Purpose : Multi-flop synchronizer for one asynchronous level. It feeds the
//           enable edge detector here and also serves the ACK_TGL return path
//           on the source side.
// Ports   : CLK      - destination clock, rising edge
//           RST      - synchronous active-high reset, clears every stage
//           ASYNC_IN - level from another clock domain
//           SYNC_OUT - ASYNC_IN delayed by NUM_STAGES flops
// ---------------------------------------------------------------------------
module bit_sync
  import sync_pkg::*;
#(
  parameter int NUM_STAGES = DEF_SYNC_STAGES
) (
  input  logic CLK,
  input  logic RST,
  input  logic ASYNC_IN,
  output logic SYNC_OUT
);

  // Reject unsupported depths when the design is elaborated.
  if (!stages_legal(NUM_STAGES)) begin : g_bad_stages
    $error("bit_sync: NUM_STAGES=%0d is outside %0d..%0d",
           NUM_STAGES, MIN_SYNC_STAGES, MAX_SYNC_STAGES);
  end

  logic [NUM_STAGES-1:0] chain_q;
  logic [NUM_STAGES-1:0] chain_d;

  // Stage 0 samples the asynchronous input; each later stage takes the one before it.
  always_comb begin
    chain_d = {chain_q[NUM_STAGES-2:0], ASYNC_IN};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign SYNC_OUT = chain_q[NUM_STAGES-1];

endmodule

// File: rtl/data_sync_ack.sv
// ---------------------------------------------------------------------------
// data_sync_ack
// Purpose : Destination side of a multi-bit transfer. The source enable level
//           is synchronized and turned into a one-cycle capture strobe. On
//           that strobe the source bus is registered and an acknowledge
//           toggle flips so the source can release its data.
// Ports   : CLK          - destination clock, rising edge
//           RST          - synchronous active-high reset
//           BUS_EN       - source enable level, asynchronous to CLK
//           UNSYNC_BUS   - source data, held stable while a transfer is open
//           SYNC_BUS     - captured word (registered)
//           ENABLE_PULSE - one-cycle strobe marking a new SYNC_BUS word
//           ACK_TGL      - flips once per captured word (registered)
// ---------------------------------------------------------------------------
module data_sync_ack
  import sync_pkg::*;
#(
  parameter int NUM_STAGES = DEF_SYNC_STAGES,
  parameter int BUS_WIDTH  = DEF_BUS_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 BUS_EN,
  input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
  output logic [BUS_WIDTH-1:0] SYNC_BUS,
  output logic                 ENABLE_PULSE,
  output logic                 ACK_TGL
);

  logic                 en_sync;
  logic                 en_prev_q;
  logic                 capture;
  logic [BUS_WIDTH-1:0] bus_q;
  logic [BUS_WIDTH-1:0] bus_d;
  logic                 pulse_q;
  logic                 pulse_d;
  logic                 ack_q;
  logic                 ack_d;

  bit_sync #(
    .NUM_STAGES(NUM_STAGES)
  ) u_en_sync (
    .CLK      (CLK),
    .RST      (RST),
    .ASYNC_IN (BUS_EN),
    .SYNC_OUT (en_sync)
  );

  // Only the rising edge of the synchronized enable opens a capture; a held
  // or falling level leaves every output quiet. Because reset clears
  // en_prev_q, an enable still high after reset produces one fresh capture.
  assign capture = en_sync & ~en_prev_q;

  always_comb begin
    bus_d   = bus_q;
    pulse_d = 1'b0;
    ack_d   = ack_q;
    if (capture) begin
      bus_d   = UNSYNC_BUS;
      pulse_d = 1'b1;
      ack_d   = ~ack_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      en_prev_q <= 1'b0;
      bus_q     <= '0;
      pulse_q   <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      en_prev_q <= en_sync;
      bus_q     <= bus_d;
      pulse_q   <= pulse_d;
      ack_q     <= ack_d;
    end
  end

  assign SYNC_BUS     = bus_q;
  assign ENABLE_PULSE = pulse_q;
  assign ACK_TGL      = ack_q;

endmodule

// File: tb/tb_data_sync_ack.sv
// ---------------------------------------------------------------------------
// tb_data_sync_ack
// Purpose : Directed bench for data_sync_ack. A 2-stage instance covers the
//           main scenarios and a 4-stage instance covers the deeper chain.
// ---------------------------------------------------------------------------
module tb_data_sync_ack;

  logic       CLK;
  logic       RST;
  logic       BUS_EN;
  logic [7:0] UNSYNC_BUS;
  logic [7:0] SYNC_BUS;
  logic       ENABLE_PULSE;
  logic       ACK_TGL;

  logic       rst4;
  logic       busEn4;
  logic [7:0] unsyncBus4;
  logic [7:0] syncBus4;
  logic       enablePulse4;
  logic       ackTgl4;

  int testsRun;
  int testsFailed;

  data_sync_ack #(
    .NUM_STAGES(2),
    .BUS_WIDTH (8)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .BUS_EN      (BUS_EN),
    .UNSYNC_BUS  (UNSYNC_BUS),
    .SYNC_BUS    (SYNC_BUS),
    .ENABLE_PULSE(ENABLE_PULSE),
    .ACK_TGL     (ACK_TGL)
  );

  data_sync_ack #(
    .NUM_STAGES(4),
    .BUS_WIDTH (8)
  ) dut4 (
    .CLK         (CLK),
    .RST         (rst4),
    .BUS_EN      (busEn4),
    .UNSYNC_BUS  (unsyncBus4),
    .SYNC_BUS    (syncBus4),
    .ENABLE_PULSE(enablePulse4),
    .ACK_TGL     (ackTgl4)
  );

  // Free-running 10-unit clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Advance one rising edge, then settle so outputs are read away from the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Compare all three outputs of the 2-stage instance against expected values.
  task automatic check2(input string name, input logic [7:0] expBus,
                        input logic expPulse, input logic expAck);
    testsRun++;
    if (SYNC_BUS !== expBus) begin
      testsFailed++;
      $display("[TB] FAIL %s SYNC_BUS got %h expected %h", name, SYNC_BUS, expBus);
    end
    testsRun++;
    if (ENABLE_PULSE !== expPulse) begin
      testsFailed++;
      $display("[TB] FAIL %s ENABLE_PULSE got %b expected %b", name, ENABLE_PULSE, expPulse);
    end
    testsRun++;
    if (ACK_TGL !== expAck) begin
      testsFailed++;
      $display("[TB] FAIL %s ACK_TGL got %b expected %b", name, ACK_TGL, expAck);
    end
  endtask

  // One-cycle reset of the 2-stage instance with the enable low.
  task automatic doReset();
    RST    = 1'b1;
    BUS_EN = 1'b0;
    tick();
    RST = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    RST        = 1'b1;
    BUS_EN     = 1'b1;
    UNSYNC_BUS = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check2("reset", 8'h00, 1'b0, 1'b0);
    end
    RST    = 1'b0;
    BUS_EN = 1'b0;
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_single();
    UNSYNC_BUS = 8'hA5;
    BUS_EN     = 1'b1;
    tick();
    check2("single_e0", 8'h00, 1'b0, 1'b0);
    tick();
    check2("single_e1", 8'h00, 1'b0, 1'b0);
    tick();
    check2("single_e2", 8'hA5, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check2("single_hold", 8'hA5, 1'b0, 1'b1);
    end
    BUS_EN = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check2("single_low", 8'hA5, 1'b0, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    doReset();
    UNSYNC_BUS = 8'h3C;
    BUS_EN     = 1'b1;
    tick();
    check2("b2b_a_e0", 8'h00, 1'b0, 1'b0);
    tick();
    check2("b2b_a_e1", 8'h00, 1'b0, 1'b0);
    tick();
    check2("b2b_a_e2", 8'h3C, 1'b1, 1'b1);
    BUS_EN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check2("b2b_a_low", 8'h3C, 1'b0, 1'b1);
    end
    UNSYNC_BUS = 8'hC3;
    BUS_EN     = 1'b1;
    tick();
    check2("b2b_b_e0", 8'h3C, 1'b0, 1'b1);
    tick();
    check2("b2b_b_e1", 8'h3C, 1'b0, 1'b1);
    tick();
    check2("b2b_b_e2", 8'hC3, 1'b1, 1'b0);
    BUS_EN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check2("b2b_b_low", 8'hC3, 1'b0, 1'b0);
    end
  endtask

  task automatic test_idle_data();
    BUS_EN = 1'b0;
    for (int i = 0; i < 10; i++) begin
      UNSYNC_BUS = (i % 2 == 0) ? 8'h11 : 8'h22;
      tick();
      check2("idle", 8'hC3, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    UNSYNC_BUS = 8'h5A;
    BUS_EN     = 1'b1;
    tick();
    RST = 1'b1;
    tick();
    check2("mid_rst", 8'h00, 1'b0, 1'b0);
    RST = 1'b0;
    tick();
    check2("mid_r1", 8'h00, 1'b0, 1'b0);
    tick();
    check2("mid_r2", 8'h00, 1'b0, 1'b0);
    tick();
    check2("mid_r3", 8'h5A, 1'b1, 1'b1);
    tick();
    check2("mid_r4", 8'h5A, 1'b0, 1'b1);
    BUS_EN = 1'b0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_stages4();
    rst4 = 1'b1;
    tick();
    rst4       = 1'b0;
    unsyncBus4 = 8'h81;
    busEn4     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      testsRun++;
      if (enablePulse4 !== 1'b0 || syncBus4 !== 8'h00 || ackTgl4 !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL stages4_e%0d got bus %h pulse %b ack %b expected 00 0 0",
                 i, syncBus4, enablePulse4, ackTgl4);
      end
    end
    tick();
    testsRun++;
    if (enablePulse4 !== 1'b1 || syncBus4 !== 8'h81 || ackTgl4 !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL stages4_e4 got bus %h pulse %b ack %b expected 81 1 1",
               syncBus4, enablePulse4, ackTgl4);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      testsRun++;
      if (enablePulse4 !== 1'b0 || syncBus4 !== 8'h81 || ackTgl4 !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL stages4_hold got bus %h pulse %b ack %b expected 81 0 1",
                 syncBus4, enablePulse4, ackTgl4);
      end
    end
    busEn4 = 1'b0;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    RST         = 1'b1;
    BUS_EN      = 1'b0;
    UNSYNC_BUS  = 8'h00;
    rst4        = 1'b1;
    busEn4      = 1'b0;
    unsyncBus4  = 8'h00;

    test_reset();
    test_single();
    test_back_to_back();
    test_idle_data();
    test_reset_mid();
    test_stages4();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/data_sync_ack.md
# data_sync_ack

Destination-side bus synchronizer for multi-bit transfers crossing into a single clock domain. It synchronizes a source-domain enable level through a parameterizable flop chain and converts it to a one-cycle capture strobe. On that strobe it registers the source bus and flips an acknowledge toggle that the source domain synchronizes back to release its data. It is the destination-side consumer of a level-to-pulse conversion: it owns the enable synchronizer that feeds the edge detector, plus the data capture and handshake logic around it.

## Interface
- NUM_STAGES, 2, synchronizer depth on BUS_EN; legal range 2..4
- BUS_WIDTH, 8, width of the transferred word
- CLK  in  1  destination-domain clock, all state on rising edge
- RST  in  1  reset; synchronous and active-high
- BUS_EN  in  1  source-domain enable level, asynchronous to CLK
- UNSYNC_BUS  in  BUS_WIDTH  source-domain data, quasi-static while a transfer is open
- SYNC_BUS  out  BUS_WIDTH  captured word, registered
- ENABLE_PULSE  out  1  one-cycle strobe: SYNC_BUS holds a new word, registered
- ACK_TGL  out  1  toggles once per captured word, registered, returned to source

## Operation
- Sync chain: NUM_STAGES flops on BUS_EN. The last-stage output is the synchronized level S.
- Edge detect: one flop holds the previous S as S_d. Capture condition is p = S & ~S_d.
- On an edge where p=1:
  - SYNC_BUS <= UNSYNC_BUS.
  - ENABLE_PULSE <= 1.
  - ACK_TGL <= ~ACK_TGL.
- On an edge where p=0:
  - SYNC_BUS holds its value.
  - ENABLE_PULSE <= 0.
  - ACK_TGL holds its value.
- A falling or held-low BUS_EN produces no activity.
- Source contract:
  - BUS_EN stays high for at least NUM_STAGES+1 CLK cycles.
  - BUS_EN then stays low for at least NUM_STAGES+1 CLK cycles before the next rise.
  - UNSYNC_BUS stays stable from the BUS_EN rise until the source sees ACK_TGL change.
- Violating the contract is out of scope; no detection is required.
- Reset: while RST=1 at a rising edge, every flop clears to 0: sync chain, S_d, SYNC_BUS, ENABLE_PULSE and ACK_TGL.
- Reset mid-transfer: any capture in progress is discarded. If BUS_EN is still high after reset releases, the chain refills and one new capture occurs, because S_d was cleared. Suppressing a duplicate is the source's responsibility.
- RST has priority over capture on the same edge.

## Timing
- Let edge 0 be the first CLK edge that samples BUS_EN=1.
- S=1 after edge NUM_STAGES-1.
- p=1 during the cycle after edge NUM_STAGES-1.
- SYNC_BUS, ENABLE_PULSE=1 and the ACK_TGL flip all become visible together after edge NUM_STAGES, i.e. NUM_STAGES+1 edges of latency.
- ENABLE_PULSE is high for exactly one cycle per BUS_EN rise, independent of how long BUS_EN stays high.
- SYNC_BUS is valid from the ENABLE_PULSE cycle until the next capture.
- Back-to-back transfers: minimum spacing is 2×(NUM_STAGES+1) CLK cycles between captures.
- Outputs have no combinational path from inputs; all three are flop outputs.

## Structure
- Shared package `sync_pkg` holds:
  - DEF_SYNC_STAGES = 2
  - DEF_BUS_WIDTH = 8
  - MIN_SYNC_STAGES = 2 and MAX_SYNC_STAGES = 4, with an elaboration check on NUM_STAGES.
- Sub-module `bit_sync`:
  - parameter NUM_STAGES; ports CLK, RST, ASYNC_IN, SYNC_OUT.
  - Same synchronous active-high reset.
  - Reused for the ACK_TGL return path on the source side.
- Edge detect, capture register and ack toggle live in the top level.

## Test plan
All scenarios use NUM_STAGES=2 and BUS_WIDTH=8.
1. Reset: RST=1 for 3 cycles with BUS_EN=1 and UNSYNC_BUS=0xFF → SYNC_BUS=0x00, ENABLE_PULSE=0, ACK_TGL=0 throughout.
2. Single transfer: UNSYNC_BUS=0xA5, BUS_EN rises and is sampled at edge 0, held 6 cycles → after edge 2: SYNC_BUS=0xA5, ENABLE_PULSE=1 for exactly 1 cycle, ACK_TGL 0→1. No further pulse while BUS_EN stays high.
3. Two transfers, 0x3C then 0xC3, spaced 6 cycles with 3-cycle high and low phases → two single-cycle pulses. SYNC_BUS=0x3C, then 0xC3. ACK_TGL 0→1→0.
4. Data change while idle: UNSYNC_BUS toggles 0x11/0x22 with BUS_EN=0 for 10 cycles → SYNC_BUS unchanged, ENABLE_PULSE=0.
5. Reset mid-operation: RST=1 for one cycle at edge 1 of a 0x5A transfer, BUS_EN held high → all outputs 0 after reset. One capture of 0x5A occurs 3 edges after RST drops, and ACK_TGL=1.
6. Parameter sweep: NUM_STAGES=4, UNSYNC_BUS=0x81 → ENABLE_PULSE appears after edge 4, 5-edge latency, single cycle.
